// File: rtl/dma_pkg.sv
// Shared types and constants for the DMA controller: command and FSM state
// encodings plus the word-address helper used for both memory sides.
package dma_pkg;

    localparam int SRAM_AW = 14;
    localparam int WIDTH_W = 10;

    typedef enum logic [1:0] {
        DMA_NONE = 2'b00,
        DMA_D2S  = 2'b01,
        DMA_S2D  = 2'b10
    } dma_cmd_e;

    typedef enum logic [3:0] {
        DORMANT   = 4'd0,
        D2S_BEGIN = 4'd1,
        D2S_READ  = 4'd2,
        D2S_WRITE = 4'd3,
        S2D_BEGIN = 4'd4,
        S2D_READ  = 4'd5,
        S2D_WRITE = 4'd6,
        NEXT      = 4'd7,
        DONE      = 4'd8
    } dma_state_e;

    // Byte address of word idx relative to base, wrapping at 32 bits.
    function automatic logic [31:0] word_addr(input logic [31:0] base,
                                              input logic [WIDTH_W-1:0] idx);
        return base + (32'(idx) << 2);
    endfunction

endpackage

// File: rtl/dma_controller_if.sv
// Bundle of core-command, SRAM and DRAM signals seen by the DMA controller.
// The master side is the controller, the slave side is the surrounding system.
interface dma_controller_if;
    import dma_pkg::*;

    logic [1:0]         cmd;
    logic [31:0]        srcAddr;
    logic [31:0]        destAddr;
    logic [WIDTH_W-1:0] width;
    logic [31:0]        sramReadData;
    logic [31:0]        dramReadData;
    logic [SRAM_AW-1:0] sramAddress;
    logic [31:0]        sramWriteData;
    logic               sramWriteEnable;
    logic [31:0]        dramAddress;
    logic [31:0]        dramWriteData;
    logic               dramWriteEnable;
    logic               dramReadEnable;
    logic               dramValid;
    logic               stall;
    logic               dmaValid;

    modport master (
        input  cmd, srcAddr, destAddr, width, sramReadData, dramReadData, dramValid,
        output sramAddress, sramWriteData, sramWriteEnable,
               dramAddress, dramWriteData, dramWriteEnable, dramReadEnable,
               stall, dmaValid
    );

    modport slave (
        output cmd, srcAddr, destAddr, width, sramReadData, dramReadData, dramValid,
        input  sramAddress, sramWriteData, sramWriteEnable,
               dramAddress, dramWriteData, dramWriteEnable, dramReadEnable,
               stall, dmaValid
    );

endinterface

// File: rtl/dma_controller.sv
// Word-by-word DMA engine between DRAM and on-chip SRAM. Stalls the core for
// the whole transfer and pulses dmaValid for one cycle when it completes.
module dma_controller
    import dma_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    dma_controller_if.master bus
);

    dma_state_e         state_q, state_d;
    logic               s2d_q, s2d_d;
    logic [WIDTH_W-1:0] idx_q, idx_d;
    logic [WIDTH_W-1:0] len_q, len_d;
    logic [31:0]        src_q, src_d;
    logic [31:0]        dest_q, dest_d;
    logic [31:0]        data_q, data_d;

    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [31:0]        sram_wdata_q, sram_wdata_d;
    logic [31:0]        dram_addr_q, dram_addr_d;
    logic [31:0]        dram_wdata_q, dram_wdata_d;
    logic               sram_we_q, sram_we_d;
    logic               dram_we_q, dram_we_d;
    logic               dram_re_q, dram_re_d;
    logic               stall_q, stall_d;
    logic               dma_valid_q, dma_valid_d;

    logic [31:0]        dram_base, sram_base;

    always_comb begin
        state_d = state_q;
        s2d_d   = s2d_q;
        idx_d   = idx_q;
        len_d   = len_q;
        src_d   = src_q;
        dest_d  = dest_q;
        data_d  = data_q;
        case (state_q)
            DORMANT: begin
                if (bus.cmd == DMA_D2S) begin
                    state_d = D2S_BEGIN;
                    s2d_d   = 1'b0;
                end else if (bus.cmd == DMA_S2D) begin
                    state_d = S2D_BEGIN;
                    s2d_d   = 1'b1;
                end
            end
            D2S_BEGIN, S2D_BEGIN: begin
                src_d  = bus.srcAddr;
                dest_d = bus.destAddr;
                len_d  = bus.width;
                idx_d  = '0;
                if (bus.width == '0)
                    state_d = DONE;
                else
                    state_d = s2d_q ? S2D_READ : D2S_READ;
            end
            D2S_READ: begin
                if (bus.dramValid) begin
                    data_d  = bus.dramReadData;
                    state_d = D2S_WRITE;
                end
            end
            D2S_WRITE: state_d = NEXT;
            S2D_READ: begin
                data_d  = bus.sramReadData;
                state_d = S2D_WRITE;
            end
            S2D_WRITE: begin
                if (bus.dramValid)
                    state_d = NEXT;
            end
            NEXT: begin
                idx_d = idx_q + WIDTH_W'(1);
                if (idx_d == len_q)
                    state_d = DONE;
                else
                    state_d = s2d_q ? S2D_READ : D2S_READ;
            end
            DONE:    state_d = DORMANT;
            default: state_d = DORMANT;
        endcase
    end

    // Outputs are decoded from the next state so they come straight off flops
    // and line up with the state they belong to.
    always_comb begin
        dram_base    = s2d_d ? dest_d : src_d;
        sram_base    = s2d_d ? src_d : dest_d;
        dram_re_d    = (state_d == D2S_READ);
        dram_we_d    = (state_d == S2D_WRITE);
        sram_we_d    = (state_d == D2S_WRITE);
        stall_d      = (state_d != DORMANT) && (state_d != DONE);
        dma_valid_d  = (state_d == DONE);
        dram_addr_d  = (dram_re_d || dram_we_d) ? word_addr(dram_base, idx_d) : '0;
        sram_addr_d  = (sram_we_d || state_d == S2D_READ)
                       ? SRAM_AW'(word_addr(sram_base, idx_d)) : '0;
        sram_wdata_d = sram_we_d ? data_d : '0;
        dram_wdata_d = dram_we_d ? data_d : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= DORMANT;
            s2d_q        <= 1'b0;
            idx_q        <= '0;
            len_q        <= '0;
            src_q        <= '0;
            dest_q       <= '0;
            data_q       <= '0;
            sram_addr_q  <= '0;
            sram_wdata_q <= '0;
            dram_addr_q  <= '0;
            dram_wdata_q <= '0;
            sram_we_q    <= 1'b0;
            dram_we_q    <= 1'b0;
            dram_re_q    <= 1'b0;
            stall_q      <= 1'b0;
            dma_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s2d_q        <= s2d_d;
            idx_q        <= idx_d;
            len_q        <= len_d;
            src_q        <= src_d;
            dest_q       <= dest_d;
            data_q       <= data_d;
            sram_addr_q  <= sram_addr_d;
            sram_wdata_q <= sram_wdata_d;
            dram_addr_q  <= dram_addr_d;
            dram_wdata_q <= dram_wdata_d;
            sram_we_q    <= sram_we_d;
            dram_we_q    <= dram_we_d;
            dram_re_q    <= dram_re_d;
            stall_q      <= stall_d;
            dma_valid_q  <= dma_valid_d;
        end
    end

    assign bus.sramAddress     = sram_addr_q;
    assign bus.sramWriteData   = sram_wdata_q;
    assign bus.sramWriteEnable = sram_we_q;
    assign bus.dramAddress     = dram_addr_q;
    assign bus.dramWriteData   = dram_wdata_q;
    assign bus.dramWriteEnable = dram_we_q;
    assign bus.dramReadEnable  = dram_re_q;
    assign bus.stall           = stall_q;
    assign bus.dmaValid        = dma_valid_q;

endmodule

// File: tb/tb_dma_controller.sv
// Randomised bench for dma_controller: memory models for SRAM and DRAM, a
// transfer-level reference model and per-beat stream checks.
module tb_dma_controller;
    import dma_pkg::*;

    logic clk = 1'b0;
    logic reset;

    dma_controller_if bus();

    dma_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    logic [31:0] sram_mem [0:4095];
    logic [31:0] dram_mem [logic [31:0]];

    assign bus.sramReadData = sram_mem[bus.sramAddress[13:2]];

    function automatic logic [31:0] dram_read(input logic [31:0] a);
        if (dram_mem.exists(a))
            return dram_mem[a];
        return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
    endfunction

    function automatic logic [31:0] outs_or();
        return 32'(bus.sramAddress) | bus.sramWriteData | bus.dramAddress | bus.dramWriteData |
               {27'd0, bus.sramWriteEnable, bus.dramWriteEnable, bus.dramReadEnable,
                bus.stall, bus.dmaValid};
    endfunction

    // Expected beat streams, filled by the reference model before each transfer.
    logic [31:0] exp_rd_q[$];
    logic [31:0] exp_sw_addr_q[$];
    logic [31:0] exp_sw_data_q[$];
    logic [31:0] exp_dw_addr_q[$];
    logic [31:0] exp_dw_data_q[$];

    int cur_delay = 0;
    int wait_cnt  = 0;
    bit noise_en  = 1'b0;

    // DRAM responder plus beat monitor, all on the falling edge.
    initial begin
        bus.dramValid    = 1'b0;
        bus.dramReadData = '0;
        forever begin
            @(negedge clk);
            if (bus.dramReadEnable || bus.dramWriteEnable) begin
                if (wait_cnt >= cur_delay) begin
                    bus.dramValid    = 1'b1;
                    bus.dramReadData = dram_read(bus.dramAddress);
                end else begin
                    bus.dramValid = 1'b0;
                    wait_cnt++;
                end
            end else begin
                wait_cnt         = 0;
                bus.dramValid    = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
                bus.dramReadData = $urandom;
            end
            if (bus.dramReadEnable && bus.dramValid) begin
                if (exp_rd_q.size() == 0) check("dram_rd_extra", bus.dramAddress, 32'hFFFF_FFFF);
                else check("dram_rd_addr", bus.dramAddress, exp_rd_q.pop_front());
            end
            if (bus.dramWriteEnable && bus.dramValid) begin
                if (exp_dw_addr_q.size() == 0) check("dram_wr_extra", bus.dramAddress, 32'hFFFF_FFFF);
                else begin
                    check("dram_wr_addr", bus.dramAddress, exp_dw_addr_q.pop_front());
                    check("dram_wr_data", bus.dramWriteData, exp_dw_data_q.pop_front());
                end
                dram_mem[bus.dramAddress] = bus.dramWriteData;
            end
            if (bus.sramWriteEnable) begin
                if (exp_sw_addr_q.size() == 0) check("sram_wr_extra", 32'(bus.sramAddress), 32'hFFFF_FFFF);
                else begin
                    check("sram_wr_addr", 32'(bus.sramAddress), exp_sw_addr_q.pop_front());
                    check("sram_wr_data", bus.sramWriteData, exp_sw_data_q.pop_front());
                end
                sram_mem[bus.sramAddress[13:2]] = bus.sramWriteData;
            end
        end
    end

    task automatic run_xfer(input logic [1:0] c, input logic [31:0] s, input logic [31:0] d,
                            input int w, input int dly, input bit inj);
        int cyc = 0;
        int first_re = -1;
        int gaps = 0;
        int en_cnt = 0;
        cur_delay = dly;
        for (int i = 0; i < w; i++) begin
            if (c == DMA_D2S) begin
                exp_rd_q.push_back(s + 32'(4 * i));
                exp_sw_addr_q.push_back((d + 32'(4 * i)) & 32'h3FFF);
                exp_sw_data_q.push_back(dram_read(s + 32'(4 * i)));
            end else begin
                exp_dw_addr_q.push_back(d + 32'(4 * i));
                exp_dw_data_q.push_back(sram_mem[((s + 32'(4 * i)) & 32'h3FFF) >> 2]);
            end
        end
        bus.cmd      = c;
        bus.srcAddr  = s;
        bus.destAddr = d;
        bus.width    = WIDTH_W'(w);
        forever begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                check("begin_stall", 32'(bus.stall), 1);
                if (c == DMA_D2S) check("begin_state", 32'(dut.state_q), 1);
            end
            if (bus.dmaValid) break;
            if (bus.stall) bus.cmd = inj ? 2'(DMA_D2S) : 2'(DMA_NONE);
            else gaps++;
            if (bus.dramReadEnable && first_re < 0) first_re = cyc;
            if (bus.sramWriteEnable || bus.dramReadEnable || bus.dramWriteEnable) en_cnt++;
            if (cyc > 3000) begin
                check("xfer_timeout", 32'(cyc), 0);
                break;
            end
        end
        bus.cmd = 2'(DMA_NONE);
        check("latency", 32'(cyc), 32'(2 + w * (dly + 3)));
        check("stall_gaps", 32'(gaps), 0);
        check("beats_left", 32'(exp_rd_q.size() + exp_sw_addr_q.size() + exp_dw_addr_q.size()), 0);
        check("done_stall", 32'(bus.stall), 0);
        if (w == 0) check("w0_enables", 32'(en_cnt), 0);
        if (c == DMA_D2S && w > 0) check("first_re_in3", 32'(first_re >= 2 && first_re <= 4), 1);
        @(negedge clk);
        check("valid_pulse", 32'(bus.dmaValid), 0);
        check("idle_stall", 32'(bus.stall), 0);
        $display("XFER %s src=%h dest=%h width=%0d delay=%0d inj=%0d cycles=%0d",
                 (c == DMA_D2S) ? "D2S" : "S2D", s, d, w, dly, inj, cyc);
    endtask

    initial begin
        reset        = 1'b0;
        bus.cmd      = 2'(DMA_NONE);
        bus.srcAddr  = '0;
        bus.destAddr = '0;
        bus.width    = '0;
        for (int i = 0; i < 4096; i++) sram_mem[i] = $urandom;

        repeat (2) @(negedge clk);
        check("rst_outs", outs_or(), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_state", 32'(dut.state_q), 0);
        check("idle_outs", outs_or(), 0);

        bus.cmd = 2'b11;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rsvd_stall", 32'(bus.stall), 0);
        end
        bus.cmd = 2'(DMA_NONE);
        @(negedge clk);

        dram_mem[32'd24] = 32'd1234;
        dram_mem[32'd28] = 32'd5678;
        dram_mem[32'd32] = 32'h0000abcd;
        dram_mem[32'd36] = 32'h0000ef12;
        run_xfer(DMA_D2S, 32'd24, 32'd12, 4, 1, 1'b0);
        check("sram12", sram_mem[3], 32'd1234);
        check("sram16", sram_mem[4], 32'd5678);
        check("sram20", sram_mem[5], 32'h0000abcd);
        check("sram24", sram_mem[6], 32'h0000ef12);
        check("plan_state", 32'(dut.state_q), 0);

        sram_mem[10] = 32'h000000A5;
        run_xfer(DMA_S2D, 32'd40, 32'd100, 1, 5, 1'b1);
        check("dram100", dram_read(32'd100), 32'h000000A5);

        run_xfer(DMA_D2S, 32'h40, 32'h80, 0, 0, 1'b0);
        run_xfer(DMA_S2D, 32'h40, 32'h80, 0, 0, 1'b1);
        run_xfer(DMA_D2S, 32'hFFFF_FFF8, 32'h3FF8, 3, 0, 1'b1);
        run_xfer(DMA_S2D, 32'h3FFC, 32'hFFFF_FFFC, 2, 2, 1'b0);

        noise_en = 1'b1;
        for (int t = 0; t < 10; t++) begin
            logic [1:0]  c;
            logic [31:0] dram_a, sram_a;
            c      = ($urandom_range(0, 1) == 0) ? 2'(DMA_D2S) : 2'(DMA_S2D);
            dram_a = $urandom & 32'hFFFF_FFFC;
            sram_a = $urandom_range(0, 16383) & 32'hFFFF_FFFC;
            if (c == DMA_D2S)
                run_xfer(c, dram_a, sram_a, $urandom_range(0, 12), $urandom_range(0, 4),
                         1'($urandom_range(0, 1)));
            else
                run_xfer(c, sram_a, dram_a, $urandom_range(0, 12), $urandom_range(0, 4),
                         1'($urandom_range(0, 1)));
        end
        noise_en = 1'b0;

        // Abort a transfer while it waits on DRAM.
        begin
            bit seen_re = 1'b0;
            cur_delay    = 40;
            bus.cmd      = 2'(DMA_D2S);
            bus.srcAddr  = 32'h1000;
            bus.destAddr = 32'h200;
            bus.width    = WIDTH_W'(5);
            for (int i = 0; i < 10 && !seen_re; i++) begin
                @(negedge clk);
                if (bus.stall) bus.cmd = 2'(DMA_NONE);
                if (bus.dramReadEnable) seen_re = 1'b1;
            end
            check("abort_re_seen", 32'(seen_re), 1);
            #2 reset = 1'b0;
            #1;
            check("abort_outs", outs_or(), 0);
            check("abort_state", 32'(dut.state_q), 0);
            @(negedge clk);
            reset = 1'b1;
            exp_rd_q.delete();
            exp_sw_addr_q.delete();
            exp_sw_data_q.delete();
            @(negedge clk);
            check("post_abort_stall", 32'(bus.stall), 0);
        end

        run_xfer(DMA_D2S, 32'h5000, 32'h100, 2, 0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
